// File: rtl/mw_wb_if.sv
// Handshake and payload bundle between the data-memory stage and the MEM/WB stage.
// The master side drives entries in and consumes writeback results; the slave side is the stage.
interface mw_wb_if #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    localparam int OFF_W = $clog2(XLEN / 8);

    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   read_data_in;
    logic [2:0]        load_funct3_in;
    logic [OFF_W-1:0]  byte_offset_in;
    logic [1:0]        wb_sel_in;
    logic              reg_write_in;
    logic [RA_W-1:0]   rd_address_in;
    logic [XLEN-1:0]   alu_result_in;
    logic [XLEN-1:0]   pc_plus_four_in;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   wb_data_out;
    logic [RA_W-1:0]   rd_address_out;
    logic              reg_write_out;
    logic [CNT_W-1:0]  stall_cycles_out;

    modport master (
        output in_valid, read_data_in, load_funct3_in, byte_offset_in, wb_sel_in,
               reg_write_in, rd_address_in, alu_result_in, pc_plus_four_in, out_ready,
        input  in_ready, out_valid, wb_data_out, rd_address_out, reg_write_out,
               stall_cycles_out
    );

    modport slave (
        input  in_valid, read_data_in, load_funct3_in, byte_offset_in, wb_sel_in,
               reg_write_in, rd_address_in, alu_result_in, pc_plus_four_in, out_ready,
        output in_ready, out_valid, wb_data_out, rd_address_out, reg_write_out,
               stall_cycles_out
    );
endinterface

// File: rtl/mw_wb_stage.sv
// MEM/WB pipeline stage: 2-entry skid buffer, flush, load extraction, writeback mux
// and a saturating backpressure counter.
module mw_wb_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     flush,
    mw_wb_if.slave   bus
);
    localparam int OFF_W = $clog2(XLEN / 8);

    typedef struct packed {
        logic [XLEN-1:0]  read_data;
        logic [2:0]       funct3;
        logic [OFF_W-1:0] byte_offset;
        logic [1:0]       wb_sel;
        logic             reg_write;
        logic [RA_W-1:0]  rd;
        logic [XLEN-1:0]  alu;
        logic [XLEN-1:0]  pc4;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_t;

    occ_t             state_r;
    occ_t             state_next_s;
    entry_t           main_r;
    entry_t           skid_r;
    entry_t           in_entry_s;
    logic [CNT_W-1:0] stall_r;
    logic             main_valid_s;
    logic             skid_valid_s;
    logic             accept_s;
    logic             transfer_s;
    logic             load_main_in_s;
    logic             load_skid_in_s;
    logic             load_main_skid_s;
    logic [XLEN-1:0]  load_data_s;
    logic [XLEN-1:0]  wb_data_s;

    // Sub-word offsets beyond the natural alignment are not trapped here; the shifted bits are used as-is.
    function automatic logic [XLEN-1:0] extract_load(
        input logic [XLEN-1:0]  data,
        input logic [2:0]       funct3,
        input logic [OFF_W-1:0] off
    );
        logic [XLEN-1:0] shifted;
        shifted = data >> {off, 3'b000};
        case (funct3)
            3'b000:  extract_load = XLEN'($signed(shifted[7:0]));
            3'b100:  extract_load = XLEN'(shifted[7:0]);
            3'b001:  extract_load = XLEN'($signed(shifted[15:0]));
            3'b101:  extract_load = XLEN'(shifted[15:0]);
            3'b010:  extract_load = XLEN'($signed(shifted[31:0]));
            3'b110:  extract_load = XLEN'(shifted[31:0]);
            3'b011:  extract_load = data;
            default: extract_load = data;
        endcase
    endfunction

    // Occupancy is decoded only from registered state so in_ready has no path from out_ready.
    assign main_valid_s = (state_r != ST_EMPTY);
    assign skid_valid_s = (state_r == ST_FULL);
    assign accept_s     = bus.in_valid & ~skid_valid_s;
    assign transfer_s   = main_valid_s & bus.out_ready;

    assign in_entry_s = '{
        read_data:   bus.read_data_in,
        funct3:      bus.load_funct3_in,
        byte_offset: bus.byte_offset_in,
        wb_sel:      bus.wb_sel_in,
        reg_write:   bus.reg_write_in,
        rd:          bus.rd_address_in,
        alu:         bus.alu_result_in,
        pc4:         bus.pc_plus_four_in
    };

    // Occupancy state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Occupancy next-state; flush dominates every transition.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: state_next_s = accept_s ? ST_ONE : ST_EMPTY;
                ST_ONE: begin
                    if (accept_s && !transfer_s) begin
                        state_next_s = ST_FULL;
                    end else if (!accept_s && transfer_s) begin
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_ONE;
                    end
                end
                ST_FULL:  state_next_s = transfer_s ? ST_ONE : ST_FULL;
                default:  state_next_s = ST_EMPTY;
            endcase
        end
    end

    // Slot load enables derived from the current occupancy.
    always_comb begin
        load_main_in_s   = 1'b0;
        load_skid_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        if (flush) begin
            load_main_in_s   = 1'b0;
            load_skid_in_s   = 1'b0;
            load_main_skid_s = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: load_main_in_s = accept_s;
                ST_ONE: begin
                    load_main_in_s = accept_s & transfer_s;
                    load_skid_in_s = accept_s & ~transfer_s;
                end
                ST_FULL:  load_main_skid_s = transfer_s;
                default: begin
                    load_main_in_s   = 1'b0;
                    load_skid_in_s   = 1'b0;
                    load_main_skid_s = 1'b0;
                end
            endcase
        end
    end

    // Main and skid payload registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_r <= {$bits(entry_t){1'b0}};
            skid_r <= {$bits(entry_t){1'b0}};
        end else begin
            if (load_main_in_s) begin
                main_r <= in_entry_s;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end
            if (load_skid_in_s) begin
                skid_r <= in_entry_s;
            end
        end
    end

    // Saturating count of stalled output cycles; flush deliberately does not clear it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_r <= {CNT_W{1'b0}};
        end else if (main_valid_s && !bus.out_ready && !(&stall_r)) begin
            stall_r <= stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Writeback source selection from the main slot.
    always_comb begin
        load_data_s = extract_load(main_r.read_data, main_r.funct3, main_r.byte_offset);
        case (main_r.wb_sel)
            2'b01:   wb_data_s = load_data_s;
            2'b10:   wb_data_s = main_r.pc4;
            default: wb_data_s = main_r.alu;
        endcase
    end

    assign bus.in_ready         = ~skid_valid_s;
    assign bus.out_valid        = main_valid_s;
    assign bus.wb_data_out      = wb_data_s;
    assign bus.rd_address_out   = main_r.rd;
    assign bus.reg_write_out    = main_valid_s & main_r.reg_write & (main_r.rd != {RA_W{1'b0}});
    assign bus.stall_cycles_out = stall_r;

endmodule

// File: tb/tb_mw_wb_stage.sv
// Randomized and directed bench for mw_wb_stage against a queue-based reference model.
module tb_mw_wb_stage;
    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    logic clk;
    logic resetn;
    logic flush;
    int   total;
    int   bad;
    exp_t q[$];
    int   m_cnt;

    mw_wb_if #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

    mw_wb_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] f3, input int off);
        logic [31:0] s;
        s = d >> (8 * off);
        case (f3)
            3'd0:    return ((s & 32'hFF) ^ 32'h80) - 32'h80;
            3'd4:    return s & 32'hFF;
            3'd1:    return ((s & 32'hFFFF) ^ 32'h8000) - 32'h8000;
            3'd5:    return s & 32'hFFFF;
            3'd2:    return s;
            3'd6:    return s;
            default: return d;
        endcase
    endfunction

    function automatic exp_t make_exp();
        exp_t e;
        case (bus.wb_sel_in)
            2'b01:   e.wb = ref_load(bus.read_data_in, bus.load_funct3_in, int'(bus.byte_offset_in));
            2'b10:   e.wb = bus.pc_plus_four_in;
            default: e.wb = bus.alu_result_in;
        endcase
        e.rd = bus.rd_address_in;
        e.rw = bus.reg_write_in && (bus.rd_address_in != 5'd0);
        return e;
    endfunction

    task automatic check_outputs();
        check_eq("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        check_eq("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        check_eq("stall_cycles", 32'(bus.stall_cycles_out), 32'(m_cnt));
        if (q.size() != 0) begin
            check_eq("wb_data", bus.wb_data_out, q[0].wb);
            check_eq("rd_address", 32'(bus.rd_address_out), 32'(q[0].rd));
            check_eq("reg_write", 32'(bus.reg_write_out), 32'(q[0].rw));
        end else begin
            check_eq("reg_write_idle", 32'(bus.reg_write_out), 32'd0);
        end
    endtask

    // One clock: model advances on the rising edge, DUT is checked on the falling edge.
    task automatic tick();
        bit acc;
        bit xfer;
        @(posedge clk);
        if (!resetn) begin
            q.delete();
            m_cnt = 0;
        end else begin
            acc  = bus.in_valid && (q.size() < 2);
            xfer = (q.size() != 0) && bus.out_ready;
            if ((q.size() != 0) && !bus.out_ready && m_cnt < CMAX) m_cnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (xfer) void'(q.pop_front());
                if (acc) q.push_back(make_exp());
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_in(input logic v, input logic [2:0] f3, input logic [1:0] off,
                          input logic [1:0] sel, input logic rw, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] data);
        bus.in_valid        = v;
        bus.load_funct3_in  = f3;
        bus.byte_offset_in  = off;
        bus.wb_sel_in       = sel;
        bus.reg_write_in    = rw;
        bus.rd_address_in   = rd;
        bus.alu_result_in   = alu;
        bus.pc_plus_four_in = pc4;
        bus.read_data_in    = data;
    endtask

    task automatic alu_entry(input logic [4:0] rd, input logic [31:0] alu);
        set_in(1'b1, 3'd0, 2'd0, 2'b00, 1'b1, rd, alu, 32'h0, 32'h0);
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] exp);
        bus.out_ready = 1'b1;
        set_in(1'b1, f3, off, 2'b01, 1'b1, 5'd7, 32'hDEAD0000, 32'h0, 32'h8899AABB);
        tick();
        check_eq(tag, bus.wb_data_out, exp);
        bus.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        clk = 1'b0;
        resetn = 1'b0;
        flush = 1'b0;
        total = 0;
        bad = 0;
        m_cnt = 0;
        bus.out_ready = 1'b0;
        set_in(1'b0, 3'd0, 2'd0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);

        @(negedge clk);
        check_outputs();
        check_eq("reset_wb_data", bus.wb_data_out, 32'h0);
        check_eq("reset_rd", 32'(bus.rd_address_out), 32'h0);
        resetn = 1'b1;
        tick();

        // Back-to-back ALU entries at full throughput.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_entry(5'(i + 1), 32'h10 + 32'(i));
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();

        // Three stalled cycles with two entries held.
        alu_entry(5'd9, 32'hA0);
        tick();
        bus.out_ready = 1'b0;
        alu_entry(5'd10, 32'hB0);
        tick();
        check_eq("in_ready_full", 32'(bus.in_ready), 32'd0);
        alu_entry(5'd11, 32'hC0);
        tick();
        tick();
        check_eq("stall_three", 32'(bus.stall_cycles_out), 32'd3);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check_eq("release_second", 32'(bus.rd_address_out), 32'd10);
        tick();

        load_case("lb_off1", 3'b000, 2'd1, 32'hFFFFFFAA);
        load_case("lhu_off2", 3'b101, 2'd2, 32'h00008899);
        load_case("lw_off0", 3'b010, 2'd0, 32'h8899AABB);
        load_case("lbu_off0", 3'b100, 2'd0, 32'h000000BB);

        // rd=0 never writes even though reg_write_in is set.
        set_in(1'b1, 3'd0, 2'd0, 2'b10, 1'b1, 5'd0, 32'h55, 32'h104, 32'h0);
        tick();
        check_eq("pc4_data", bus.wb_data_out, 32'h104);
        check_eq("rd0_no_write", 32'(bus.reg_write_out), 32'd0);
        bus.in_valid = 1'b0;
        tick();

        // Flush while full with a simultaneous incoming entry.
        bus.out_ready = 1'b0;
        alu_entry(5'd12, 32'h120);
        tick();
        alu_entry(5'd13, 32'h130);
        tick();
        flush = 1'b1;
        alu_entry(5'd14, 32'h140);
        tick();
        check_eq("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("flush_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("flush_reg_write", 32'(bus.reg_write_out), 32'd0);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();

        // Asynchronous reset with both slots occupied.
        bus.out_ready = 1'b0;
        alu_entry(5'd15, 32'h150);
        tick();
        alu_entry(5'd16, 32'h160);
        tick();
        bus.in_valid = 1'b0;
        resetn = 1'b0;
        #1;
        q.delete();
        m_cnt = 0;
        check_outputs();
        check_eq("async_rst_wb", bus.wb_data_out, 32'h0);
        tick();
        resetn = 1'b1;
        bus.out_ready = 1'b1;
        alu_entry(5'd17, 32'h170);
        tick();
        check_eq("post_reset_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b0;
        tick();

        // Long stall drives the counter into saturation.
        bus.out_ready = 1'b0;
        alu_entry(5'd18, 32'h180);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_eq("stall_saturate", 32'(bus.stall_cycles_out), 32'(CMAX));
        bus.out_ready = 1'b1;
        tick();

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   $urandom, $urandom, $urandom);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 29) == 0);
            tick();
        end
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mw_wb_stage.md
Name: mw_wb_stage

Overview:
- Parametrised MEM/WB pipeline stage with a valid/ready handshake and a 2-entry skid buffer, so the stage sustains full throughput under backpressure.
- Adds flush, load byte/half extraction with sign/zero extension, the final writeback-source mux, and a saturating backpressure counter.
- Sits between the data-memory stage and the register file write port.
- Its outputs also feed the forwarding unit.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- RA_W, 5, register address width.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  drop all held entries (trap/redirect).
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- read_data_in  in  XLEN  raw memory read word.
- load_funct3_in  in  3  load type (RISC-V funct3).
- byte_offset_in  in  log2(XLEN/8)  low address bits of the load.
- wb_sel_in  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 ALU.
- reg_write_in  in  1  instruction writes rd.
- rd_address_in  in  RA_W  destination register.
- alu_result_in  in  XLEN  ALU result.
- pc_plus_four_in  in  XLEN  link value.
- out_valid  out  1  output entry valid.
- out_ready  in  1  register file / downstream accepts.
- wb_data_out  out  XLEN  selected, extended writeback value.
- rd_address_out  out  RA_W  destination of output entry.
- reg_write_out  out  1  equals out_valid & reg_write & (rd != 0).
- stall_cycles_out  out  CNT_W  saturating count of out_valid & !out_ready cycles.

Behaviour:
- Reset: asynchronous on resetn low.
  - All valid bits, payload registers and the counter clear to 0.
  - out_valid=0, reg_write_out=0, rd_address_out=0, wb_data_out=0, stall_cycles_out=0.
  - in_ready=1.
  - Reset mid-transfer discards both entries.
- Storage: main slot (drives outputs) and skid slot. in_ready = !skid_valid, decoded only from the registered skid_valid; no combinational path from out_ready.
- Accept when in_valid & in_ready. Output transfer when out_valid & out_ready.
- Occupancy states and transitions:
  - EMPTY:
    - accept -> ONE (payload into main).
  - ONE:
    - accept & transfer -> ONE (main reloaded).
    - accept & !transfer -> FULL (payload into skid).
    - transfer & !accept -> EMPTY.
  - FULL (in_ready=0):
    - transfer -> ONE (skid moves to main, skid_valid cleared).
    - otherwise hold.
- Latency: accept in cycle N -> out_valid in cycle N+1 when EMPTY or when ONE with a simultaneous transfer.
- Ordering: strict FIFO; no entry is duplicated or reordered.
- Flush: synchronous and dominant.
  - Both valid bits clear next edge; any same-cycle accept is discarded; state -> EMPTY.
  - Payload registers may hold stale values; outputs are qualified by out_valid.
  - reg_write_out=0 while invalid.
- Load extraction is combinational from main-slot registered fields.
  - shifted = read_data >> (8*byte_offset).
  - 000 LB: sign-extend shifted[7:0]. 100 LBU: zero-extend shifted[7:0].
  - 001 LH: sign-extend shifted[15:0]. 101 LHU: zero-extend shifted[15:0].
  - 010 LW: sign-extend shifted[31:0]. 110 LWU: zero-extend shifted[31:0] (XLEN=64 only; at XLEN=32 behaves as LW).
  - 011 LD: full word.
  - Other codes: unshifted read_data.
  - Misaligned half/word: use the shifted bits as-is; no trap generated here.
- Writeback mux: 01 -> extracted load, 10 -> pc_plus_four, 00/11 -> alu_result.
- rd=0 never produces reg_write_out=1.
- Counter: increments on each cycle with out_valid & !out_ready; saturates at all-ones; cleared only by reset, not by flush.

Test Plan:
- Reset low mid-stream with both slots full -> outputs 0 immediately, in_ready=1, counter 0; after release, first accepted entry appears 1 cycle later.
- out_ready=1 throughout, 4 back-to-back ALU entries (rd=1..4, alu=0x10..0x13) -> one entry per cycle, in order, out_valid never drops.
- out_ready=0 for 3 cycles during streaming:
  - in_ready falls after the second accept.
  - stall_cycles_out=3.
  - Release delivers both held entries in order with no loss.
- LB of 0x8899AABB at offset 1 -> wb_data_out=0xFFFFFFAA.
- LHU of 0x8899AABB at offset 2 -> 0x00008899.
- LW/LBU at offset 0 -> 0x8899AABB / 0x000000BB.
- flush while FULL and in_valid=1 -> next cycle out_valid=0, in_ready=1, reg_write_out=0; the incoming entry never appears.
- Entry with rd=0, reg_write_in=1, wb_sel=10, pc+4=0x104 -> wb_data_out=0x104, reg_write_out=0.
